rx_fir_align: RTL and testbench

RX_FIR_ALIGN -- requirements
Module: rx_fir_align

---
 rtl/rx_fir_align.sv | 190 +++++++++++++++++++
 tb/tb_rx_fir_align.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_fir_align.sv
// Aligns four independently strobed rx filter outputs into frames via per-channel FIFOs.
// Optional debug bus enabled by defining RX_FIR_ALIGN_DEBUG_EN.
module rx_fir_align #(
    parameter int FIFO_AW = 3
) (
    input  logic         logic_clk_in,
    input  logic         logic_rst_in,
    input  logic [31:0]  data_fir0_in,
    input  logic [31:0]  data_fir1_in,
    input  logic [31:0]  data_fir2_in,
    input  logic [31:0]  data_fir3_in,
    input  logic         fir0_rdy_in,
    input  logic         fir1_rdy_in,
    input  logic         fir2_rdy_in,
    input  logic         fir3_rdy_in,
    input  logic         data_rdy_in,
    output logic [31:0]  data_ch0_out,
    output logic [31:0]  data_ch1_out,
    output logic [31:0]  data_ch2_out,
    output logic [31:0]  data_ch3_out,
    output logic         data_vld_out,
    output logic         sync_out,
    output logic [3:0]   ovf_err_out,
    input  logic         err_clr_in,
    output logic [199:0] debug_signal
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW+1)'(DEPTH);

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [31:0]        data_in [4];
    logic [3:0]         strb;
    logic [FIFO_AW-1:0] wr_ptr_q [4];
    logic [FIFO_AW-1:0] wr_ptr_d [4];
    logic [FIFO_AW-1:0] rd_ptr_q [4];
    logic [FIFO_AW-1:0] rd_ptr_d [4];
    logic [FIFO_AW:0]   cnt_q [4];
    logic [FIFO_AW:0]   cnt_d [4];
    logic [31:0]        fifo_mem_q [4][DEPTH];
    logic [31:0]        data_q [4];
    logic [31:0]        data_d [4];
    logic               vld_q, vld_d;
    logic [3:0]         ovf_q, ovf_d;

    logic               align;
    logic               pop;
    logic [3:0]         nonempty;
    logic [3:0]         full;
    logic [3:0]         wr_req;
    logic [3:0]         wr_acc;
    logic [3:0]         ovf_set;
    logic               flush;

    assign strb = {fir3_rdy_in, fir2_rdy_in, fir1_rdy_in, fir0_rdy_in};

    always_comb begin
        data_in[0] = data_fir0_in;
        data_in[1] = data_fir1_in;
        data_in[2] = data_fir2_in;
        data_in[3] = data_fir3_in;
    end

    // Control decode: alignment, frame pop, per-channel write/overflow.
    always_comb begin
        align = (state_q == SYNC) && (&strb);
        for (int n = 0; n < 4; n++) begin
            nonempty[n] = (cnt_q[n] != '0);
            full[n]     = (cnt_q[n] == CNT_FULL);
        end
        pop = (state_q == RUN) && (&nonempty) && data_rdy_in;
        for (int n = 0; n < 4; n++) begin
            wr_req[n]  = (state_q == RUN) ? strb[n] : align;
            ovf_set[n] = (state_q == RUN) && strb[n] && full[n] && !pop;
        end
        flush = |ovf_set;
        for (int n = 0; n < 4; n++) begin
            // A full FIFO still accepts a write when the same cycle pops it.
            wr_acc[n] = wr_req[n] && !(full[n] && !pop) && !flush;
        end
    end

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            wr_ptr_d[n] = wr_ptr_q[n];
            rd_ptr_d[n] = rd_ptr_q[n];
            cnt_d[n]    = cnt_q[n];
            data_d[n]   = data_q[n];
        end
        vld_d   = pop;
        ovf_d   = (ovf_q & ~{4{err_clr_in}}) | ovf_set;
        state_d = state_q;

        for (int n = 0; n < 4; n++) begin
            if (flush || ((state_q == SYNC) && !align)) begin
                wr_ptr_d[n] = '0;
                rd_ptr_d[n] = '0;
                cnt_d[n]    = '0;
            end else begin
                wr_ptr_d[n] = wr_ptr_q[n] + {{(FIFO_AW-1){1'b0}}, wr_acc[n]};
                rd_ptr_d[n] = rd_ptr_q[n] + {{(FIFO_AW-1){1'b0}}, pop};
                cnt_d[n]    = cnt_q[n] + {{FIFO_AW{1'b0}}, wr_acc[n]}
                                       - {{FIFO_AW{1'b0}}, pop};
            end
            if (pop) begin
                data_d[n] = fifo_mem_q[n][rd_ptr_q[n]];
            end
        end

        case (state_q)
            SYNC:    if (align) state_d = RUN;
            RUN:     if (flush) state_d = SYNC;
            default: state_d = SYNC;
        endcase
    end

    // Sample storage carries no reset; occupancy is tracked by the counters.
    always_ff @(posedge logic_clk_in) begin
        for (int n = 0; n < 4; n++) begin
            if (wr_acc[n]) begin
                fifo_mem_q[n][wr_ptr_q[n]] <= data_in[n];
            end
        end
    end

    always_ff @(posedge logic_clk_in or posedge logic_rst_in) begin
        if (logic_rst_in) begin
            state_q <= SYNC;
            vld_q   <= 1'b0;
            ovf_q   <= 4'b0;
            for (int n = 0; n < 4; n++) begin
                wr_ptr_q[n] <= '0;
                rd_ptr_q[n] <= '0;
                cnt_q[n]    <= '0;
                data_q[n]   <= '0;
            end
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            ovf_q   <= ovf_d;
            for (int n = 0; n < 4; n++) begin
                wr_ptr_q[n] <= wr_ptr_d[n];
                rd_ptr_q[n] <= rd_ptr_d[n];
                cnt_q[n]    <= cnt_d[n];
                data_q[n]   <= data_d[n];
            end
        end
    end

    assign data_ch0_out = data_q[0];
    assign data_ch1_out = data_q[1];
    assign data_ch2_out = data_q[2];
    assign data_ch3_out = data_q[3];
    assign data_vld_out = vld_q;
    assign sync_out     = (state_q == RUN);
    assign ovf_err_out  = ovf_q;

`ifdef RX_FIR_ALIGN_DEBUG_EN
    logic [199:0] debug_q, debug_d;

    // Registered snapshot so the bus reads zero under reset regardless of strobes.
    always_comb begin
        debug_d        = '0;
        debug_d[3:0]   = nonempty;
        debug_d[7:4]   = strb;
        debug_d[8]     = (state_q == RUN);
        debug_d[12:9]  = ovf_q;
        debug_d[44:13] = data_q[0];
    end

    always_ff @(posedge logic_clk_in or posedge logic_rst_in) begin
        if (logic_rst_in) begin
            debug_q <= '0;
        end else begin
            debug_q <= debug_d;
        end
    end

    assign debug_signal = debug_q;
`else
    assign debug_signal = '0;
`endif

endmodule

// File: tb/tb_rx_fir_align.sv
// Directed self-checking bench for rx_fir_align (default build, FIFO_AW=3).
module tb_rx_fir_align;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  d0, d1, d2, d3;
    logic         s0, s1, s2, s3;
    logic         rdy;
    logic [31:0]  q0, q1, q2, q3;
    logic         vld;
    logic         sync;
    logic [3:0]   ovf;
    logic         clr;
    logic [199:0] dbg;

    int tests = 0;
    int fails = 0;

    rx_fir_align #(.FIFO_AW(3)) dut (
        .logic_clk_in (clk),
        .logic_rst_in (rst),
        .data_fir0_in (d0),
        .data_fir1_in (d1),
        .data_fir2_in (d2),
        .data_fir3_in (d3),
        .fir0_rdy_in  (s0),
        .fir1_rdy_in  (s1),
        .fir2_rdy_in  (s2),
        .fir3_rdy_in  (s3),
        .data_rdy_in  (rdy),
        .data_ch0_out (q0),
        .data_ch1_out (q1),
        .data_ch2_out (q2),
        .data_ch3_out (q3),
        .data_vld_out (vld),
        .sync_out     (sync),
        .ovf_err_out  (ovf),
        .err_clr_in   (clr),
        .debug_signal (dbg)
    );

    always #2.5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] fw(input int k, input int n);
        fw = 32'hA000_0000 | (32'(k) << 8) | 32'(n);
    endfunction

    task automatic drive_all(input int k);
        d0 = fw(k, 0); d1 = fw(k, 1); d2 = fw(k, 2); d3 = fw(k, 3);
        s0 = 1; s1 = 1; s2 = 1; s3 = 1;
    endtask

    task automatic idle();
        s0 = 0; s1 = 0; s2 = 0; s3 = 0;
    endtask

    task automatic test_reset();
        rst = 1; clr = 0; rdy = 0; idle();
        d0 = 0; d1 = 0; d2 = 0; d3 = 0;
        tick(); tick();
        tests++;
        if ({vld, sync, ovf} !== 6'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b expected 000000", {vld, sync, ovf});
        end
        tests++;
        if ({q0, q1, q2, q3} !== 128'b0) begin
            fails++; $display("FAIL reset_data: got %h expected 0", {q0, q1, q2, q3});
        end
        tests++;
        if (dbg !== 200'b0) begin
            fails++; $display("FAIL reset_debug: got %h expected 0", dbg);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_align();
        rdy = 1;
        d0 = 32'h0001_0001; d1 = 32'h0002_0002; d2 = 32'h0003_0003; d3 = 32'h0004_0004;
        s0 = 1; s1 = 1; s2 = 1; s3 = 1;
        tick();
        idle();
        tests++;
        if ({vld, sync} !== 2'b01) begin
            fails++; $display("FAIL align_first: got vld,sync=%b expected 01", {vld, sync});
        end
        tick();
        tests++;
        if (vld !== 1'b1 || sync !== 1'b1) begin
            fails++; $display("FAIL align_vld: got vld,sync=%b expected 11", {vld, sync});
        end
        tests++;
        if ({q0, q1, q2, q3} !== 128'h00010001_00020002_00030003_00040004) begin
            fails++; $display("FAIL align_data: got %h expected 00010001000200020003000300040004", {q0, q1, q2, q3});
        end
        tick();
        tests++;
        if (vld !== 1'b0 || q2 !== 32'h0003_0003) begin
            fails++; $display("FAIL align_hold: got vld=%b q2=%h expected 0 00030003", vld, q2);
        end
        tests++;
        if (dbg !== 200'b0) begin
            fails++; $display("FAIL debug_zero: got %h expected 0", dbg);
        end
    endtask

    task automatic test_skew();
        int pulses = 0;
        int at = -1;
        rdy = 1;
        d0 = fw(1, 0); s0 = 1;
        tick(); if (vld) pulses++;
        idle();
        tick(); if (vld) pulses++;
        tick(); if (vld) pulses++;
        d1 = fw(1, 1); d2 = fw(1, 2); d3 = fw(1, 3);
        s1 = 1; s2 = 1; s3 = 1;
        tick(); if (vld) pulses++;
        idle();
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (vld) begin pulses++; at = c; end
        end
        tests++;
        if (pulses !== 1 || at !== 1) begin
            fails++; $display("FAIL skew_pulse: got pulses=%0d at=%0d expected 1 at 1", pulses, at);
        end
        tests++;
        if ({q0, q3} !== {fw(1, 0), fw(1, 3)}) begin
            fails++; $display("FAIL skew_data: got %h expected %h", {q0, q3}, {fw(1, 0), fw(1, 3)});
        end
    endtask

    task automatic fill8();
        int bad = 0;
        rdy = 0;
        for (int k = 0; k < 8; k++) begin
            drive_all(k);
            tick();
            if (vld || ovf != 0) bad++;
        end
        idle();
        tests++;
        if (bad !== 0 || sync !== 1'b1) begin
            fails++; $display("FAIL fill_quiet: got bad=%0d sync=%b expected 0 1", bad, sync);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        fill8();
        rdy = 1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (vld !== 1'b1 || {q0, q1, q2, q3} !== {fw(k, 0), fw(k, 1), fw(k, 2), fw(k, 3)}) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++; $display("FAIL bp_drain: got %0d bad frames expected 0", bad);
        end
        tick();
        tests++;
        if (vld !== 1'b0) begin
            fails++; $display("FAIL bp_end: got vld=%b expected 0", vld);
        end
    endtask

    task automatic test_full_pop();
        int bad = 0;
        fill8();
        rdy = 1;
        drive_all(8);
        tick();
        idle();
        tests++;
        if (ovf !== 4'b0 || vld !== 1'b1 || q1 !== fw(0, 1)) begin
            fails++; $display("FAIL fullpop: got ovf=%b vld=%b q1=%h expected 0000 1 %h", ovf, vld, q1, fw(0, 1));
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (vld !== 1'b1 || {q0, q3} !== {fw(k, 0), fw(k, 3)}) bad++;
        end
        tick();
        if (vld !== 1'b0) bad++;
        tests++;
        if (bad !== 0 || sync !== 1'b1) begin
            fails++; $display("FAIL fullpop_count: got bad=%0d sync=%b expected 0 1", bad, sync);
        end
    endtask

    task automatic test_overflow();
        int pulses = 0;
        rdy = 0;
        for (int k = 0; k < 8; k++) begin
            d2 = fw(k, 2); s2 = 1;
            tick();
        end
        tests++;
        if (ovf !== 4'b0 || sync !== 1'b1) begin
            fails++; $display("FAIL ovf_pre: got ovf=%b sync=%b expected 0000 1", ovf, sync);
        end
        tick();
        s2 = 0;
        tests++;
        if (ovf !== 4'b0100 || sync !== 1'b0) begin
            fails++; $display("FAIL ovf_set: got ovf=%b sync=%b expected 0100 0", ovf, sync);
        end
        rdy = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (vld) pulses++;
        end
        tests++;
        if (pulses !== 0 || ovf !== 4'b0100) begin
            fails++; $display("FAIL ovf_empty: got pulses=%0d ovf=%b expected 0 0100", pulses, ovf);
        end
        clr = 1;
        tick();
        clr = 0;
        tests++;
        if (ovf !== 4'b0) begin
            fails++; $display("FAIL ovf_clr: got %b expected 0000", ovf);
        end
    endtask

    task automatic test_set_wins();
        rdy = 0;
        drive_all(0);
        tick();
        idle();
        for (int k = 0; k < 7; k++) begin
            s1 = 1; tick();
        end
        s1 = 1; clr = 1;
        tick();
        s1 = 0; clr = 0;
        tests++;
        if (ovf !== 4'b0010 || sync !== 1'b0) begin
            fails++; $display("FAIL set_wins: got ovf=%b sync=%b expected 0010 0", ovf, sync);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        rdy = 0;
        for (int k = 0; k < 3; k++) begin
            drive_all(k + 3);
            tick();
        end
        idle();
        rst = 1;
        #1;
        tests++;
        if ({vld, sync, ovf} !== 6'b0 || {q0, q1, q2, q3} !== 128'b0) begin
            fails++; $display("FAIL rst_mid: got ctrl=%b data=%h expected 0", {vld, sync, ovf}, {q0, q1, q2, q3});
        end
        tick();
        rst = 0;
        rdy = 1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (vld) pulses++;
        end
        tests++;
        if (pulses !== 0 || sync !== 1'b0) begin
            fails++; $display("FAIL rst_discard: got pulses=%0d sync=%b expected 0 0", pulses, sync);
        end
        drive_all(9);
        tick();
        idle();
        tick();
        tests++;
        if (vld !== 1'b1 || {q0, q2} !== {fw(9, 0), fw(9, 2)}) begin
            fails++; $display("FAIL rst_realign: got vld=%b data=%h expected 1 %h", vld, {q0, q2}, {fw(9, 0), fw(9, 2)});
        end
    endtask

    initial begin
        test_reset();
        test_align();
        test_skew();
        test_backpressure();
        test_full_pop();
        test_overflow();
        test_set_wins();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
